// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one-line (64-bit) buffer over a valid/ready read bus.
// Sequential fetches within a line hit combinationally; redirects discard in-flight responses.
module if_fetch_unit #(
  parameter logic [60:0] RESET_TAG = 61'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic        pc_en_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_stall_o,
  output logic        fetch_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [63:0] mem_req_addr_o,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_resp_data_i,
  input  logic        mem_resp_err_i
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned TAGW = 61;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t            state;
  logic              buf_valid;
  logic [TAGW-1:0]   tag;
  logic [XLEN-1:0]   data;
  logic              flush_pend;

  logic aligned;
  logic hit;
  logic misalign;
  logic start;

  assign aligned  = (pc_i[1:0] == 2'b00);
  assign hit      = buf_valid & pc_en_i & (pc_i[63:3] == tag) & aligned & ~fetch_err_o;
  assign misalign = pc_en_i & ~aligned;
  assign start    = pc_en_i & ~hit & aligned & ~fetch_err_o & ~flush_i;

  assign inst_o        = pc_i[2] ? data[63:32] : data[31:0];
  assign inst_valid_o  = hit;
  // Any open transaction stalls unless the current PC is already buffered.
  assign fetch_stall_o = ~rst & ~hit & ((state != IDLE) | (pc_en_i & ~fetch_err_o));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      buf_valid       <= 1'b0;
      tag             <= RESET_TAG;
      data            <= '0;
      flush_pend      <= 1'b0;
      fetch_err_o     <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
    end else begin
      if (flush_i) begin
        fetch_err_o <= 1'b0;
      end else if (misalign) begin
        fetch_err_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mem_req_addr_o  <= {pc_i[63:3], 3'b000};
            mem_req_valid_o <= 1'b1;
            flush_pend      <= 1'b0;
            state           <= REQ;
          end
        end
        REQ: begin
          // Valid is never withdrawn; a flush here only marks the response for discard.
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            flush_pend      <= 1'b0;
            state           <= (flush_i | flush_pend) ? DROP : WAIT;
          end else if (flush_i) begin
            flush_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            state <= IDLE;
            if (!flush_i) begin
              if (mem_resp_err_i) begin
                fetch_err_o <= 1'b1;
                buf_valid   <= 1'b0;
              end else begin
                data      <= mem_resp_data_i;
                tag       <= mem_req_addr_o[63:3];
                buf_valid <= 1'b1;
              end
            end
          end else if (flush_i) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (mem_resp_valid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response is only legal while one is outstanding.
  resp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst)
    mem_resp_valid_i |-> (state == WAIT || state == DROP)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: hit/miss timing, stalled bus, flushes, errors and reset.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_en_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        fetch_stall_o;
  logic        fetch_err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_data_i;
  logic        mem_resp_err_i;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.RESET_TAG(61'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .pc_en_i          (pc_en_i),
    .flush_i          (flush_i),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o),
    .fetch_stall_o    (fetch_stall_o),
    .fetch_err_o      (fetch_err_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_err_i   (mem_resp_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic resp(input logic v, input logic [63:0] d, input logic e);
    mem_resp_valid_i = v;
    mem_resp_data_i  = d;
    mem_resp_err_i   = e;
  endtask

  initial begin
    rst = 1'b1; pc_i = '0; pc_en_i = 1'b0; flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    resp(1'b0, 64'h0, 1'b0);
    nxt(); nxt();
    mid();
    chk("rst_inst",   64'(inst_o), 64'h0);
    chk("rst_ivalid", 64'(inst_valid_o), 64'h0);
    chk("rst_stall",  64'(fetch_stall_o), 64'h0);
    chk("rst_err",    64'(fetch_err_o), 64'h0);
    chk("rst_reqv",   64'(mem_req_valid_o), 64'h0);
    chk("rst_addr",   mem_req_addr_o, 64'h0);
    nxt();
    rst = 1'b0;

    // Zero-wait fetch of 0x80000000
    pc_i = 64'h8000_0000; pc_en_i = 1'b1; mem_req_ready_i = 1'b1;
    mid();
    chk("t1_c0_stall", 64'(fetch_stall_o), 64'h1);
    chk("t1_c0_reqv",  64'(mem_req_valid_o), 64'h0);
    nxt();
    mid();
    chk("t1_c1_reqv", 64'(mem_req_valid_o), 64'h1);
    chk("t1_c1_addr", mem_req_addr_o, 64'h8000_0000);
    nxt();
    resp(1'b1, 64'h0000_0013_0010_0093, 1'b0);
    mid();
    chk("t1_c2_stall", 64'(fetch_stall_o), 64'h1);
    chk("t1_c2_reqv",  64'(mem_req_valid_o), 64'h0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    mid();
    chk("t1_c3_inst",   64'(inst_o), 64'h0010_0093);
    chk("t1_c3_ivalid", 64'(inst_valid_o), 64'h1);
    chk("t1_c3_stall",  64'(fetch_stall_o), 64'h0);
    nxt();
    pc_i = 64'h8000_0004;
    mid();
    chk("t1_c4_inst",  64'(inst_o), 64'h0000_0013);
    chk("t1_c4_stall", 64'(fetch_stall_o), 64'h0);
    nxt();
    mid();
    chk("t1_c5_reqv", 64'(mem_req_valid_o), 64'h0);
    nxt();

    // Four ready-low cycles and a two-cycle response delay
    pc_i = 64'h8000_0008;
    for (int i = 0; i < 8; i++) begin
      mem_req_ready_i = (i == 5);
      resp((i == 7), 64'hAAAA_0002_BBBB_0001, 1'b0);
      mid();
      chk($sformatf("t2_c%0d_stall", i), 64'(fetch_stall_o), 64'h1);
      chk($sformatf("t2_c%0d_reqv", i), 64'(mem_req_valid_o), 64'((i >= 1) && (i <= 5)));
      if ((i >= 1) && (i <= 5))
        chk($sformatf("t2_c%0d_addr", i), mem_req_addr_o, 64'h8000_0008);
      nxt();
    end
    resp(1'b0, 64'h0, 1'b0);
    mem_req_ready_i = 1'b1;
    mid();
    chk("t2_hit_inst",  64'(inst_o), 64'hBBBB_0001);
    chk("t2_hit_stall", 64'(fetch_stall_o), 64'h0);
    chk("t2_hit_reqv",  64'(mem_req_valid_o), 64'h0);
    nxt();

    // Flush in WAIT; old line still hits during DROP, then refetch
    pc_i = 64'h8000_0010;
    mid();
    chk("t3_c0_stall", 64'(fetch_stall_o), 64'h1);
    nxt();
    mid();
    chk("t3_c1_addr", mem_req_addr_o, 64'h8000_0010);
    nxt();
    flush_i = 1'b1; pc_i = 64'h8000_0100;
    mid();
    chk("t3_c2_stall", 64'(fetch_stall_o), 64'h1);
    nxt();
    flush_i = 1'b0; pc_i = 64'h8000_0008;
    resp(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    mid();
    chk("t3_drop_inst",  64'(inst_o), 64'hBBBB_0001);
    chk("t3_drop_stall", 64'(fetch_stall_o), 64'h0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    mid();
    chk("t3_nofill_inst", 64'(inst_o), 64'hBBBB_0001);
    chk("t3_nofill_ivld", 64'(inst_valid_o), 64'h1);
    chk("t3_c4_reqv",     64'(mem_req_valid_o), 64'h0);
    nxt();
    pc_i = 64'h8000_0100;
    mid();
    chk("t3_c5_stall", 64'(fetch_stall_o), 64'h1);
    nxt();
    mid();
    chk("t3_c6_reqv", 64'(mem_req_valid_o), 64'h1);
    chk("t3_c6_addr", mem_req_addr_o, 64'h8000_0100);
    nxt();
    resp(1'b1, 64'h1111_1111_2222_2222, 1'b0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    mid();
    chk("t3_hit_inst",  64'(inst_o), 64'h2222_2222);
    chk("t3_hit_stall", 64'(fetch_stall_o), 64'h0);
    nxt();

    // Flush in REQ with ready low
    pc_i = 64'h8000_0200; mem_req_ready_i = 1'b0;
    nxt();
    flush_i = 1'b1; pc_i = 64'h8000_0300;
    mid();
    chk("t4_c1_reqv", 64'(mem_req_valid_o), 64'h1);
    chk("t4_c1_addr", mem_req_addr_o, 64'h8000_0200);
    nxt();
    flush_i = 1'b0;
    mid();
    chk("t4_c2_reqv", 64'(mem_req_valid_o), 64'h1);
    chk("t4_c2_addr", mem_req_addr_o, 64'h8000_0200);
    nxt();
    mem_req_ready_i = 1'b1;
    nxt();
    mem_req_ready_i = 1'b0;
    resp(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    mid();
    chk("t4_drop_stall", 64'(fetch_stall_o), 64'h1);
    chk("t4_drop_reqv",  64'(mem_req_valid_o), 64'h0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    mid();
    chk("t4_c5_ivalid", 64'(inst_valid_o), 64'h0);
    nxt();
    mem_req_ready_i = 1'b1;
    mid();
    chk("t4_c6_addr", mem_req_addr_o, 64'h8000_0300);
    nxt();
    resp(1'b1, 64'h3333_3333_4444_4444, 1'b0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    pc_i = 64'h8000_0304;
    mid();
    chk("t4_hit_inst", 64'(inst_o), 64'h3333_3333);
    nxt();

    // Error response: sticky, no requests, buffer invalidated; flush clears
    pc_i = 64'h8000_0400;
    nxt();
    nxt();
    resp(1'b1, 64'h0, 1'b1);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("t5_c%0d_err", i), 64'(fetch_err_o), 64'h1);
      chk($sformatf("t5_c%0d_reqv", i), 64'(mem_req_valid_o), 64'h0);
      chk($sformatf("t5_c%0d_ivalid", i), 64'(inst_valid_o), 64'h0);
      nxt();
    end
    flush_i = 1'b1;
    nxt();
    flush_i = 1'b0; pc_i = 64'h8000_0304;
    mid();
    chk("t5_clr_err",   64'(fetch_err_o), 64'h0);
    chk("t5_inv_ivld",  64'(inst_valid_o), 64'h0);
    chk("t5_inv_stall", 64'(fetch_stall_o), 64'h1);
    nxt();
    nxt();
    resp(1'b1, 64'h5555_5555_6666_6666, 1'b0);
    nxt();
    resp(1'b0, 64'h0, 1'b0);
    mid();
    chk("t5_refill_inst", 64'(inst_o), 64'h5555_5555);
    nxt();

    // Misaligned PC
    pc_i = 64'h8000_0002;
    mid();
    chk("t6_c0_err",  64'(fetch_err_o), 64'h0);
    chk("t6_c0_reqv", 64'(mem_req_valid_o), 64'h0);
    nxt();
    mid();
    chk("t6_c1_err",  64'(fetch_err_o), 64'h1);
    chk("t6_c1_reqv", 64'(mem_req_valid_o), 64'h0);
    nxt();
    flush_i = 1'b1; pc_i = 64'h8000_0300;
    mid();
    chk("t6_c2_reqv", 64'(mem_req_valid_o), 64'h0);
    nxt();
    flush_i = 1'b0;
    mid();
    chk("t6_c3_err",  64'(fetch_err_o), 64'h0);
    chk("t6_c3_inst", 64'(inst_o), 64'h6666_6666);
    nxt();

    // Asynchronous reset in WAIT
    pc_i = 64'h8000_0500;
    nxt();
    nxt();
    rst = 1'b1;
    #1;
    chk("t7_inst",   64'(inst_o), 64'h0);
    chk("t7_ivalid", 64'(inst_valid_o), 64'h0);
    chk("t7_stall",  64'(fetch_stall_o), 64'h0);
    chk("t7_err",    64'(fetch_err_o), 64'h0);
    chk("t7_reqv",   64'(mem_req_valid_o), 64'h0);
    chk("t7_addr",   mem_req_addr_o, 64'h0);
    pc_en_i = 1'b0;
    nxt();
    rst = 1'b0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
